// File: rtl/param_pkg.sv
// Shared constants and types for the UART receive path.
// UART_RX_MAJORITY_EN selects 2-of-3 majority bit sampling in uart_rx_sampler.
package param_pkg;

    localparam int DWIDTH   = 6;
    localparam int PRESCALE = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int FRAME_BITS_NOPAR = 2 + DWIDTH;
    localparam int FRAME_BITS_PAR   = 3 + DWIDTH;

    function automatic int frameCycles(input int dw, input int prescale, input bit parEn);
        return (2 + dw + (parEn ? 1 : 0)) * prescale;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit edge counter and bit-sample strobes for uart_rx.
// UART_RX_MAJORITY_EN: decide each bit by 2-of-3 majority around the bit centre.
module uart_rx_sampler #(
    parameter int PRESCALE = param_pkg::PRESCALE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in_i,
    input  logic active_i,
    output logic rx_s_o,
    output logic sample_bit_o,
    output logic sample_stb_o,
    output logic bit_end_stb_o
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] SAMPLE_AT = CW'(PRESCALE / 2);
    localparam logic [CW-1:0] END_AT    = CW'(PRESCALE - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] edge_cnt_q;
    logic [CW-1:0] edge_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            edge_cnt_q <= '0;
        end else begin
            sync_q     <= {sync_q[0], rx_in_i};
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign rx_s_o = sync_q[1];

    // The counter idles at zero, so the first cycle of a start bit is count 0.
    always_comb begin
        edge_cnt_d = '0;
        if (active_i && edge_cnt_q != END_AT) begin
            edge_cnt_d = edge_cnt_q + 1'b1;
        end
    end

    assign bit_end_stb_o = active_i && (edge_cnt_q == END_AT);

`ifdef UART_RX_MAJORITY_EN
    logic early_q;
    logic mid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            early_q <= 1'b1;
            mid_q   <= 1'b1;
        end else begin
            if (edge_cnt_q == SAMPLE_AT - 1'b1) early_q <= rx_s_o;
            if (edge_cnt_q == SAMPLE_AT)        mid_q   <= rx_s_o;
        end
    end

    assign sample_bit_o = (early_q & mid_q) | (early_q & rx_s_o) | (mid_q & rx_s_o);
    assign sample_stb_o = active_i && (edge_cnt_q == SAMPLE_AT + 1'b1);
`else
    assign sample_bit_o = rx_s_o;
    assign sample_stb_o = active_i && (edge_cnt_q == SAMPLE_AT);
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DWIDTH data bits LSB first, optional parity, one stop bit.
// UART_RX_MAJORITY_EN (in uart_rx_sampler) delays frame-end outputs by one cycle.
module uart_rx #(
    parameter int DWIDTH   = param_pkg::DWIDTH,
    parameter int PRESCALE = param_pkg::PRESCALE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    input  logic              par_en,
    input  logic              par_typ,
    output logic [DWIDTH-1:0] p_data,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic              busy
);

    import param_pkg::*;

    localparam int BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DWIDTH - 1);

    rx_state_e         state_q, state_d;
    logic [DWIDTH-1:0] shift_q, shift_d;
    logic [DWIDTH-1:0] p_data_q, p_data_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              par_en_q, par_en_d;
    logic              par_typ_q, par_typ_d;
    logic              par_bad_q, par_bad_d;
    logic              valid_q, valid_d;
    logic              par_err_q, par_err_d;
    logic              stp_err_q, stp_err_d;
    logic              rx_s, sample_bit, sample_stb, bit_end_stb;

    uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_in_i       (rx_in),
        .active_i      (busy),
        .rx_s_o        (rx_s),
        .sample_bit_o  (sample_bit),
        .sample_stb_o  (sample_stb),
        .bit_end_stb_o (bit_end_stb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // STOP leaves at its sample point so a following start bit is never missed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rx_s) state_d = START;
            START: begin
                if (sample_stb && sample_bit) state_d = IDLE;
                else if (bit_end_stb)         state_d = DATA;
            end
            DATA:    if (bit_end_stb && bit_cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end_stb) state_d = STOP;
            STOP:    if (sample_stb) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    always_comb begin
        shift_d   = shift_q;
        p_data_d  = p_data_q;
        bit_cnt_d = bit_cnt_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_bad_d = par_bad_q;
        valid_d   = 1'b0;
        par_err_d = 1'b0;
        stp_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    par_en_d  = par_en;
                    par_typ_d = par_typ;
                    bit_cnt_d = '0;
                    par_bad_d = 1'b0;
                end
            end
            DATA: begin
                if (sample_stb) shift_d[bit_cnt_q] = sample_bit;
                if (bit_end_stb && bit_cnt_q != LAST_BIT) bit_cnt_d = bit_cnt_q + 1'b1;
            end
            PARITY: begin
                if (sample_stb && ((^shift_q ^ par_typ_q) != sample_bit)) par_bad_d = 1'b1;
            end
            STOP: begin
                if (sample_stb) begin
                    stp_err_d = !sample_bit;
                    par_err_d = par_bad_q;
                    valid_d   = sample_bit && !par_bad_q;
                    if (sample_bit && !par_bad_q) p_data_d = shift_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            p_data_q  <= '0;
            bit_cnt_q <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_bad_q <= 1'b0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            p_data_q  <= p_data_d;
            bit_cnt_q <= bit_cnt_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            par_bad_q <= par_bad_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
        end
    end

    assign p_data     = p_data_q;
    assign data_valid = valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx (DWIDTH=6, PRESCALE=8); expectations are queued
// as frames are sent and a monitor pops them whenever a frame-end pulse appears.
module tb_uart_rx;

    localparam int DW = 6;
    localparam int PS = 8;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 64;
    localparam logic [5:0] GLITCH_WORD = 6'h2D;
`else
    localparam int LAT = 63;
    localparam logic [5:0] GLITCH_WORD = 6'h12;
`endif

    typedef struct {
        bit         dv;
        bit         pe;
        bit         se;
        logic [5:0] data;
        int         expCyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_in;
    logic          par_en;
    logic          par_typ;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          busy;

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   done = 1'b0;

    uart_rx #(.DWIDTH(DW), .PRESCALE(PS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expectEvent(input bit dv, input bit pe, input bit se, input logic [5:0] data, input int expCyc);
        exp_t e;
        e.dv = dv; e.pe = pe; e.se = se; e.data = data; e.expCyc = expCyc;
        expQ.push_back(e);
    endtask

    // Drives one bit period; g inverts the rx_in cycle that lands on the centre sample.
    task automatic driveBit(input bit v, input bit g);
        for (int i = 0; i < PS; i++) begin
            rx_in = (g && i == 5) ? ~v : v;
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] data, input bit parEn, input bit parBit,
                                 input bit stopBit, input bit glitch);
        driveBit(1'b0, 1'b0);
        for (int k = 0; k < DW; k++) driveBit(data[k], glitch);
        if (parEn) driveBit(parBit, 1'b0);
        driveBit(stopBit, 1'b0);
        rx_in = 1'b1;
    endtask

    task automatic monitorLoop();
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (data_valid || par_err || stp_err) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_pulse: dv=%0b pe=%0b se=%0b data=%0h, expected none",
                             data_valid, par_err, stp_err, p_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("data_valid", data_valid, e.dv);
                    checkOutput("par_err", par_err, e.pe);
                    checkOutput("stp_err", stp_err, e.se);
                    checkOutput("p_data", p_data, e.data);
                    if (e.expCyc >= 0) checkOutput("latency_cycle", cyc, e.expCyc);
                end
            end
        end
    endtask

    task automatic runTests();
        int startCyc;

        startCyc = cyc + 1;
        expectEvent(1, 0, 0, 6'h2D, startCyc + LAT);
        applyStimulus(6'h2D, 0, 0, 1, 0);
        repeat (10) @(negedge clk);

        par_en = 1'b1;
        par_typ = 1'b0;
        expectEvent(1, 0, 0, 6'h15, -1);
        applyStimulus(6'h15, 1, 1, 1, 0);
        repeat (10) @(negedge clk);
        expectEvent(0, 1, 0, 6'h15, -1);
        applyStimulus(6'h15, 1, 0, 1, 0);
        repeat (10) @(negedge clk);
        par_en = 1'b0;

        expectEvent(0, 0, 1, 6'h15, -1);
        applyStimulus(6'h0A, 0, 0, 0, 0);
        repeat (16) @(negedge clk);
        checkOutput("busy_after_stop_err", busy, 0);

        expectEvent(1, 0, 0, 6'h01, -1);
        expectEvent(1, 0, 0, 6'h3E, -1);
        applyStimulus(6'h01, 0, 0, 1, 0);
        applyStimulus(6'h3E, 0, 0, 1, 0);
        repeat (10) @(negedge clk);

        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("glitch_busy_high", busy, 1);
        repeat (10) @(negedge clk);
        checkOutput("glitch_busy_low", busy, 0);
        expectEvent(1, 0, 0, 6'h33, -1);
        applyStimulus(6'h33, 0, 0, 1, 0);
        repeat (10) @(negedge clk);

        driveBit(1'b0, 1'b0);
        driveBit(1'b1, 1'b0);
        driveBit(1'b0, 1'b0);
        driveBit(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midframe_rst_p_data", p_data, 0);
        checkOutput("midframe_rst_valid", data_valid, 0);
        checkOutput("midframe_rst_par_err", par_err, 0);
        checkOutput("midframe_rst_stp_err", stp_err, 0);
        checkOutput("midframe_rst_busy", busy, 0);
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        expectEvent(1, 0, 0, 6'h2A, -1);
        applyStimulus(6'h2A, 0, 0, 1, 0);
        repeat (10) @(negedge clk);

        expectEvent(1, 0, 0, GLITCH_WORD, -1);
        applyStimulus(6'h2D, 0, 0, 1, 1);

        for (int i = 0; i < 300 && expQ.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        checkOutput("queue_drained", expQ.size(), 0);
        done = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        rx_in = 1'b1;
        par_en = 1'b0;
        par_typ = 1'b0;
        #12;
        checkOutput("reset_p_data", p_data, 0);
        checkOutput("reset_valid", data_valid, 0);
        checkOutput("reset_par_err", par_err, 0);
        checkOutput("reset_stp_err", stp_err, 0);
        checkOutput("reset_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        fork
            monitorLoop();
            runTests();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
